sync_fifo_ext: RTL and testbench
================================

// Module: sync_fifo_ext
// PURPOSE
//  Single-clock FIFO, next generation of the team's sync FIFO. Adds a selectable read mode
//  (standard or first-word-fall-through), write/read protection at full/empty, overflow/underflow
//  and wr_ack pulses, a valid strobe, and registered status flags. Used for intra-domain buffering
//  between stream producers and consumers on sys_clk_i.
// PARAMETERS
//  FIFO_DEEP       1024  total capacity in words; power of two, >= 4
//  DATA_WIDTH      8     word width in bits
//  READ_MODE       0     0 = STD (dout one cycle after rd_en), 1 = FWFT (head word pre-presented)
//  PROG_FULL_NUM   1000  prog_full asserts when data_count >= this; range 1..FIFO_DEEP
//  PROG_EMPTY_NUM  4     prog_empty asserts when data_count <= this; range 0..FIFO_DEEP-1
//  ADDR_W (local)  clogb2(FIFO_DEEP)
// PORTS
//  sys_clk_i   in   1             clock
//  rst_n_i     in   1             reset, asynchronous, active-low
//  wr_en       in   1             write request
//  din         in   DATA_WIDTH    write data
//  full        out  1             data_count == FIFO_DEEP
//  prog_full   out  1             programmable full
//  wr_ack      out  1             pulse: previous-cycle write accepted
//  overflow    out  1             pulse: previous-cycle write rejected (full)
//  rd_en       in   1             read request (STD) / pop (FWFT)
//  dout        out  DATA_WIDTH    read data
//  valid       out  1             dout holds a valid word
//  empty       out  1             no word readable
//  prog_empty  out  1             programmable empty
//  underflow   out  1             pulse: previous-cycle read rejected (empty)
//  data_count  out  ADDR_W+1      words stored (FWFT: includes output register)
// BEHAVIOUR
//  - Reset: pointers, data_count, dout = 0; empty = prog_empty = 1; full, prog_full, valid,
//    wr_ack, overflow, underflow = 0. Reset mid-operation discards all contents immediately;
//    RAM is not cleared, only made unreachable.
//  - Write accepted iff wr_en & !full (registered full, sampled at the edge). Rejected write:
//    RAM/pointers unchanged, overflow = 1 for the next cycle. Accepted: wr_ack = 1 next cycle.
//  - All flags are registered from next-state count; they reflect the post-edge occupancy.
//    No combinational look-ahead terms.
//  - Pointers are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1). RAM address = low ADDR_W bits.
//  - STD: read accepted iff rd_en & !empty. dout updates and valid = 1 the cycle after the
//    accepting edge; otherwise valid = 0 and dout holds its last value.
//    empty = (data_count == 0).
//  - FWFT: one output register in front of the RAM. Prefetch issues a RAM read when the RAM is
//    non-empty and (output register empty, or popped this cycle). Pop accepted iff rd_en & valid.
//    empty = !valid. A write into an empty FIFO gives valid = 1 two edges later.
//    Back-to-back pops sustain 1 word/cycle with no bubbles.
//  - Rejected read (rd_en while empty): no state change; underflow = 1 for the next cycle.
//  - Simultaneous wr_en & rd_en:
//    - at full: read accepted, write rejected (overflow).
//    - at empty: write accepted, read rejected (underflow).
//    - otherwise: both accepted, data_count unchanged.
//  - prog_full = (data_count >= PROG_FULL_NUM); prog_empty = (data_count <= PROG_EMPTY_NUM).
//    Both registered.
// STRUCTURE
//  - fifo_pkg: clogb2 function, READ_MODE_STD = 0 / READ_MODE_FWFT = 1 constants.
//  - Sub-module: existing simple_double_port_ram (both ports on sys_clk_i, 1-cycle sync read).
//  - FWFT prefetch/output stage inside a generate block selected by READ_MODE.
// TESTING (FIFO_DEEP=16, DATA_WIDTH=8, PROG_FULL_NUM=14, PROG_EMPTY_NUM=2; both READ_MODEs)
//  1. Reset, then idle
//     -> empty = 1, prog_empty = 1, data_count = 0, valid = 0, dout = 8'h00.
//  2. Write 0x00..0x0F, then one extra write of 0xAA
//     -> full = 1 after the 16th write; prog_full = 1 from data_count = 14;
//        overflow pulses once; 0xAA is never read back.
//  3. Drain 16 words, then one more rd_en
//     -> dout order 0x00..0x0F; underflow pulses once; empty = 1; prog_empty = 1 from count 2.
//  4. FWFT: single write 0x5A into an empty FIFO
//     -> valid = 1 and dout = 0x5A two edges later without rd_en; rd_en pop -> valid = 0.
//  5. At full, assert wr_en & rd_en together for 1 cycle
//     -> read accepted, write rejected (overflow = 1), data_count = 15.
//  6. Stream 40 words with wr_en & rd_en held high and count in 4..8
//     -> pointers wrap twice, data_count constant, data in order, no overflow/underflow.
//  7. Assert rst_n_i low mid-stream at count 9
//     -> all outputs take reset values asynchronously; the next write then reads back correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the sync FIFO family.
//   - READ_MODE_STD / READ_MODE_FWFT : values for the READ_MODE parameter
//   - clogb2()                       : ceil(log2(n)) for address sizing
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int READ_MODE_STD  = 0;
  localparam int READ_MODE_FWFT = 1;

  // Smallest r such that 2**r >= depth (depth >= 1).
  function automatic int clogb2(input int unsigned depth);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) begin
        r = int'(i) + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/simple_double_port_ram.sv
// ---------------------------------------------------------------------------
// simple_double_port_ram
//   One write port, one read port, both on sys_clk_i. Read is synchronous
//   with one cycle of latency; rd_data holds its value while rd_en is low.
//   The array itself is never reset, only the read register is.
// Ports
//   sys_clk_i  in   clock
//   rst_n_i    in   async active-low reset (read register only)
//   wr_en      in   write strobe
//   wr_addr    in   write address (ADDR_W)
//   wr_data    in   write data (DATA_WIDTH)
//   rd_en      in   read strobe
//   rd_addr    in   read address (ADDR_W)
//   rd_data    out  registered read data (DATA_WIDTH)
// ---------------------------------------------------------------------------
module simple_double_port_ram #(
  parameter int ADDR_W     = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge sys_clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_ext.sv
// ---------------------------------------------------------------------------
// sync_fifo_ext
//   Single-clock FIFO with selectable read mode:
//     READ_MODE_STD  : dout/valid appear the cycle after an accepted rd_en.
//     READ_MODE_FWFT : head word is pre-presented; rd_en pops it.
//   Writes at full and reads at empty are rejected and reported via
//   overflow/underflow pulses. All status flags are registered from the
//   next-state occupancy.
// Ports
//   sys_clk_i   in   clock
//   rst_n_i     in   async active-low reset
//   wr_en       in   write request
//   din         in   write data
//   full        out  data_count == FIFO_DEEP
//   prog_full   out  data_count >= PROG_FULL_NUM
//   wr_ack      out  previous-cycle write accepted
//   overflow    out  previous-cycle write rejected
//   rd_en       in   read request (STD) / pop (FWFT)
//   dout        out  read data
//   valid       out  dout holds a valid word
//   empty       out  no word readable
//   prog_empty  out  data_count <= PROG_EMPTY_NUM
//   underflow   out  previous-cycle read rejected
//   data_count  out  stored words (FWFT: includes output register)
// ---------------------------------------------------------------------------
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter  int FIFO_DEEP      = 1024,
  parameter  int DATA_WIDTH     = 8,
  parameter  int READ_MODE      = READ_MODE_STD,
  parameter  int PROG_FULL_NUM  = 1000,
  parameter  int PROG_EMPTY_NUM = 4,
  localparam int ADDR_W         = clogb2(FIFO_DEEP)
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  prog_full,
  output logic                  wr_ack,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  prog_empty,
  output logic                  underflow,
  output logic [ADDR_W:0]       data_count
);

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEEP);
  localparam logic [ADDR_W:0] PF_CNT   = (ADDR_W+1)'(PROG_FULL_NUM);
  localparam logic [ADDR_W:0] PE_CNT   = (ADDR_W+1)'(PROG_EMPTY_NUM);

  if (FIFO_DEEP < 4 || (FIFO_DEEP & (FIFO_DEEP - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo_ext: FIFO_DEEP must be a power of two >= 4");
  end
  if (PROG_FULL_NUM < 1 || PROG_FULL_NUM > FIFO_DEEP) begin : g_chk_pf
    $error("sync_fifo_ext: PROG_FULL_NUM out of range");
  end
  if (PROG_EMPTY_NUM < 0 || PROG_EMPTY_NUM > FIFO_DEEP - 1) begin : g_chk_pe
    $error("sync_fifo_ext: PROG_EMPTY_NUM out of range");
  end

  // Pointers carry one extra wrap bit; only the low ADDR_W bits address RAM.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] ram_words;
  logic [ADDR_W:0] count_nxt;

  logic wr_acc;     // write accepted this edge
  logic rd_acc;     // read (STD) / pop (FWFT) accepted this edge
  logic rd_rej;     // read request rejected this edge
  logic ram_rd;     // RAM read issued this edge
  logic valid_nxt;
  logic empty_nxt;

  assign wr_acc    = wr_en & ~full;
  assign ram_words = wr_ptr - rd_ptr;
  assign count_nxt = data_count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);

  if (READ_MODE == READ_MODE_FWFT) begin : g_fwft
    // The RAM read register doubles as the output register. It is refilled
    // whenever RAM holds a word and the register is empty or being popped,
    // so a continuous pop stream never leaves a bubble.
    assign rd_acc    = rd_en & valid;
    assign rd_rej    = rd_en & ~valid;
    assign ram_rd    = (ram_words != '0) & (~valid | rd_acc);
    assign valid_nxt = ram_rd | (valid & ~rd_acc);
    assign empty_nxt = ~valid_nxt;
  end else begin : g_std
    assign rd_acc    = rd_en & ~empty;
    assign rd_rej    = rd_en & empty;
    assign ram_rd    = rd_acc;
    assign valid_nxt = rd_acc;
    assign empty_nxt = (count_nxt == '0);
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      empty      <= 1'b1;
      prog_empty <= 1'b1;
      valid      <= 1'b0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + CNT_ONE;
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + CNT_ONE;
      end
      data_count <= count_nxt;
      full       <= (count_nxt == FULL_CNT);
      prog_full  <= (count_nxt >= PF_CNT);
      empty      <= empty_nxt;
      prog_empty <= (count_nxt <= PE_CNT);
      valid      <= valid_nxt;
      wr_ack     <= wr_acc;
      overflow   <= wr_en & ~wr_acc;
      underflow  <= rd_rej;
    end
  end

  simple_double_port_ram #(
    .ADDR_W     (ADDR_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .sys_clk_i (sys_clk_i),
    .rst_n_i   (rst_n_i),
    .wr_en     (wr_acc),
    .wr_addr   (wr_ptr[ADDR_W-1:0]),
    .wr_data   (din),
    .rd_en     (ram_rd),
    .rd_addr   (rd_ptr[ADDR_W-1:0]),
    .rd_data   (dout)
  );

  // Occupancy must always equal the words left in RAM plus, in FWFT mode,
  // the word parked in the output register.
  logic out_hold;
  assign out_hold = (READ_MODE == READ_MODE_FWFT) && valid;

  a_count_consistent : assert property (
    @(posedge sys_clk_i) disable iff (!rst_n_i)
      data_count == ram_words + (ADDR_W+1)'(out_hold)
  );

endmodule

// File: tb/tb_sync_fifo_ext.sv
module tb_sync_fifo_ext;

  localparam int DEPTH = 16;
  localparam int PF    = 14;
  localparam int PE    = 2;

  typedef struct packed {
    logic [4:0] cnt;
    logic       full;
    logic       pf;
    logic       empty;
    logic       pe;
    logic       wr_ack;
    logic       ovf;
    logic       udf;
    logic       vld;
  } st_t;

  localparam st_t RST_ST = '{cnt: 5'd0, full: 1'b0, pf: 1'b0, empty: 1'b1, pe: 1'b1,
                             wr_ack: 1'b0, ovf: 1'b0, udf: 1'b0, vld: 1'b0};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din   = '0;

  logic       std_full, std_pf, std_ack, std_ovf, std_vld, std_empty, std_pe, std_udf;
  logic [7:0] std_dout;
  logic [4:0] std_cnt;
  logic       fw_full, fw_pf, fw_ack, fw_ovf, fw_vld, fw_empty, fw_pe, fw_udf;
  logic [7:0] fw_dout;
  logic [4:0] fw_cnt;
  st_t        std_st, fw_st;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [7:0] mq_std[$];
  logic [7:0] mq_fw[$];
  bit         fw_vm = 1'b0;
  // Scoreboard queues
  logic [7:0] exp_std[$];
  logic [7:0] exp_fw[$];
  st_t        stq_std[$];
  st_t        stq_fw[$];

  always #5 clk = ~clk;

  sync_fifo_ext #(
    .FIFO_DEEP(DEPTH), .DATA_WIDTH(8), .READ_MODE(0),
    .PROG_FULL_NUM(PF), .PROG_EMPTY_NUM(PE)
  ) u_std (
    .sys_clk_i(clk), .rst_n_i(rst_n), .wr_en(wr_en), .din(din),
    .full(std_full), .prog_full(std_pf), .wr_ack(std_ack), .overflow(std_ovf),
    .rd_en(rd_en), .dout(std_dout), .valid(std_vld), .empty(std_empty),
    .prog_empty(std_pe), .underflow(std_udf), .data_count(std_cnt)
  );

  sync_fifo_ext #(
    .FIFO_DEEP(DEPTH), .DATA_WIDTH(8), .READ_MODE(1),
    .PROG_FULL_NUM(PF), .PROG_EMPTY_NUM(PE)
  ) u_fwft (
    .sys_clk_i(clk), .rst_n_i(rst_n), .wr_en(wr_en), .din(din),
    .full(fw_full), .prog_full(fw_pf), .wr_ack(fw_ack), .overflow(fw_ovf),
    .rd_en(rd_en), .dout(fw_dout), .valid(fw_vld), .empty(fw_empty),
    .prog_empty(fw_pe), .underflow(fw_udf), .data_count(fw_cnt)
  );

  assign std_st = {std_cnt, std_full, std_pf, std_empty, std_pe, std_ack, std_ovf, std_udf, std_vld};
  assign fw_st  = {fw_cnt, fw_full, fw_pf, fw_empty, fw_pe, fw_ack, fw_ovf, fw_udf, fw_vld};

  function automatic void chk(input string nm, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  function automatic void cmp_st(input string m, input st_t e, input st_t a);
    chk({m, "_data_count"}, int'(a.cnt),    int'(e.cnt));
    chk({m, "_full"},       int'(a.full),   int'(e.full));
    chk({m, "_prog_full"},  int'(a.pf),     int'(e.pf));
    chk({m, "_empty"},      int'(a.empty),  int'(e.empty));
    chk({m, "_prog_empty"}, int'(a.pe),     int'(e.pe));
    chk({m, "_wr_ack"},     int'(a.wr_ack), int'(e.wr_ack));
    chk({m, "_overflow"},   int'(a.ovf),    int'(e.ovf));
    chk({m, "_underflow"},  int'(a.udf),    int'(e.udf));
    chk({m, "_valid"},      int'(a.vld),    int'(e.vld));
  endfunction

  function automatic st_t mk_st(input int n, input bit ack, input bit ovf,
                                input bit udf, input bit vld, input bit emp);
    st_t s;
    s.cnt    = 5'(n);
    s.full   = (n == DEPTH);
    s.pf     = (n >= PF);
    s.empty  = emp;
    s.pe     = (n <= PE);
    s.wr_ack = ack;
    s.ovf    = ovf;
    s.udf    = udf;
    s.vld    = vld;
    return s;
  endfunction

  // One clock of stimulus. Acceptance is decided from the model's state
  // before the edge; the expected post-edge status is queued after it.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r);
    bit s_wr, s_rd, f_wr, f_rd;
    int pre;
    wr_en = w;
    din   = d;
    rd_en = r;
    s_wr = w && (mq_std.size() < DEPTH);
    s_rd = r && (mq_std.size() > 0);
    f_wr = w && (mq_fw.size() < DEPTH);
    f_rd = r && fw_vm;
    if (s_rd) exp_std.push_back(mq_std[0]);
    if (f_rd) exp_fw.push_back(mq_fw[0]);
    @(posedge clk);
    if (s_rd) void'(mq_std.pop_front());
    if (s_wr) mq_std.push_back(d);
    // FWFT head is presented once a word stored before this edge remains.
    pre = mq_fw.size();
    if (f_rd) void'(mq_fw.pop_front());
    fw_vm = (pre - int'(f_rd)) > 0;
    if (f_wr) mq_fw.push_back(d);
    stq_std.push_back(mk_st(mq_std.size(), s_wr, w && !s_wr, r && !s_rd, s_rd, mq_std.size() == 0));
    stq_fw.push_back(mk_st(mq_fw.size(), f_wr, w && !f_wr, r && !f_rd, fw_vm, !fw_vm));
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    cmp_st("std_rst", RST_ST, std_st);
    cmp_st("fwft_rst", RST_ST, fw_st);
    chk("std_rst_dout", int'(std_dout), 0);
    chk("fwft_rst_dout", int'(fw_dout), 0);
    mq_std.delete();
    mq_fw.delete();
    exp_std.delete();
    exp_fw.delete();
    fw_vm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: status every cycle, data whenever the DUT presents a word.
  always @(negedge clk) begin
    st_t        e;
    logic [7:0] x;
    if (stq_std.size() != 0) begin
      e = stq_std.pop_front();
      cmp_st("std", e, std_st);
    end
    if (stq_fw.size() != 0) begin
      e = stq_fw.pop_front();
      cmp_st("fwft", e, fw_st);
    end
    if (std_vld === 1'b1) begin
      chk("std_read_expected", int'(exp_std.size() != 0), 1);
      if (exp_std.size() != 0) begin
        x = exp_std.pop_front();
        chk("std_dout", int'(std_dout), int'(x));
      end
    end
    if (fw_vld === 1'b1 && rd_en === 1'b1) begin
      chk("fwft_pop_expected", int'(exp_fw.size() != 0), 1);
      if (exp_fw.size() != 0) begin
        x = exp_fw.pop_front();
        chk("fwft_dout", int'(fw_dout), int'(x));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    repeat (2) cycle(1'b0, 8'h00, 1'b0);

    // Fill to full, then one extra write that must be dropped
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    // Simultaneous write/read at full: read wins, write overflows
    cycle(1'b1, 8'hBB, 1'b1);
    cycle(1'b1, 8'h10, 1'b0);
    // Drain everything plus one extra read
    repeat (DEPTH + 1) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Single word into an empty FIFO
    cycle(1'b1, 8'h5A, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);

    // Steady stream at mid occupancy, pointers wrap
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1);
    repeat (8) cycle(1'b0, 8'h00, 1'b1);

    // Reset in the middle of traffic
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset();
    cycle(1'b1, 8'h3C, 1'b0);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);

    // Randomized traffic with varying write/read pressure
    for (int p = 0; p < 12; p++) begin
      int unsigned pw;
      int unsigned pr;
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
      end
    end

    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    chk("std_pending_reads", exp_std.size(), 0);
    chk("fwft_pending_pops", exp_fw.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
